// File: rtl/uart_mmio_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_mmio_responder_pkg -- register map, CON bits, UART frame/FSM types
// Rev    : 1.0
// ============================================================================
package uart_mmio_responder_pkg;

    localparam logic [31:0] c_txd_offset = 32'h0000_0000;
    localparam logic [31:0] c_rxd_offset = 32'h0000_0004;
    localparam logic [31:0] c_con_offset = 32'h0000_0008;

    localparam int c_con_tx_ie     = 0;
    localparam int c_con_rx_ie     = 1;
    localparam int c_con_tx_done   = 2;
    localparam int c_con_rx_ready  = 3;
    localparam int c_con_tx_busy   = 4;
    localparam int c_con_frame_err = 5;
    localparam int c_con_overrun   = 6;

    localparam logic       c_line_idle     = 1'b1;
    localparam logic       c_start_level   = 1'b0;
    localparam logic       c_stop_level    = 1'b1;
    localparam logic [2:0] c_last_data_bit = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_responder_rx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core -- 2-flop synchronizer and 8N1 receive FSM
// Rev    : 1.0
// ============================================================================
module uart_rx_core
    import uart_mmio_responder_pkg::*;
#(
    parameter int BAUD_DIV = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] c_bit_last  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] c_half_last = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    logic          r_sync1, r_sync2, r_prev;
    uart_state_t   r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          r_stop_wait, w_stop_wait_n;
    logic          r_valid, w_valid;
    logic          r_ferr, w_ferr;
    logic          w_line;

    assign w_line       = r_sync2;
    assign rx_byte      = r_shift;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= c_line_idle;
            r_sync2     <= c_line_idle;
            r_prev      <= c_line_idle;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_stop_wait <= 1'b0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sync1     <= uart_rx;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bit       <= w_bit_n;
            r_shift     <= w_shift_n;
            r_stop_wait <= w_stop_wait_n;
            r_valid     <= w_valid;
            r_ferr      <= w_ferr;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_bit_n       = r_bit;
        w_shift_n     = r_shift;
        w_stop_wait_n = r_stop_wait;
        w_valid       = 1'b0;
        w_ferr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_n = '0;
                if (r_prev && !w_line) begin
                    w_state_n = ST_START;
                end
            end
            ST_START: begin
                // Mid-start-bit check rejects short low glitches.
                if (r_cnt == c_half_last) begin
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = (w_line == c_start_level) ? ST_DATA : ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_n   = '0;
                    w_shift_n = {w_line, r_shift[7:1]};
                    w_bit_n   = r_bit + 3'd1;
                    if (r_bit == c_last_data_bit) begin
                        w_state_n = ST_STOP;
                    end
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            ST_STOP: begin
                // After a bad stop bit, hold here until the line returns high.
                if (r_stop_wait) begin
                    if (w_line == c_line_idle) begin
                        w_stop_wait_n = 1'b0;
                        w_state_n     = ST_IDLE;
                    end
                end else if (r_cnt == c_bit_last) begin
                    w_cnt_n = '0;
                    if (w_line == c_stop_level) begin
                        w_valid   = 1'b1;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_ferr        = 1'b1;
                        w_stop_wait_n = 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module : uart_mmio_responder -- MMIO UART slave: TXD/RXD/CON registers, TX FSM, irq
// Rev    : 1.0
// ============================================================================
module uart_mmio_responder
    import uart_mmio_responder_pkg::*;
#(
    parameter int          BAUD_DIV  = 10417,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] c_bit_last = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [31:0]   c_txd_addr = BASE_ADDR + c_txd_offset;
    localparam logic [31:0]   c_rxd_addr = BASE_ADDR + c_rxd_offset;
    localparam logic [31:0]   c_con_addr = BASE_ADDR + c_con_offset;

    logic w_sel_txd, w_sel_rxd, w_sel_con;
    logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;

    // Write wins when both strobes are high, so read side effects are gated.
    assign w_sel_txd = (addr == c_txd_addr);
    assign w_sel_rxd = (addr == c_rxd_addr);
    assign w_sel_con = (addr == c_con_addr);
    assign w_wr_txd  = mem_wr & w_sel_txd;
    assign w_wr_con  = mem_wr & w_sel_con;
    assign w_rd_rxd  = mem_rd & ~mem_wr & w_sel_rxd;
    assign w_rd_con  = mem_rd & ~mem_wr & w_sel_con;

    logic [7:0] r_txd, r_rx_data;
    logic       r_tx_ie, r_rx_ie, r_tx_done, r_rx_ready, r_frame_err, r_overrun;
    logic       r_irq;
    logic       w_tx_busy;
    logic [6:0] w_con;

    uart_state_t   r_tx_state, w_tx_state_n;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]    r_tx_bit, w_tx_bit_n;
    logic [7:0]    r_tx_shift, w_tx_shift_n;
    logic          w_tx_load, w_tx_done_set;

    logic [7:0] w_rx_byte;
    logic       w_rx_valid, w_rx_ferr;
    logic       w_unused;

    assign w_unused = ^wdata[31:8];

    uart_rx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx_core (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rx_byte     (w_rx_byte),
        .rx_valid    (w_rx_valid),
        .rx_frame_err(w_rx_ferr)
    );

    assign w_tx_busy = (r_tx_state != ST_IDLE);
    assign w_con     = {r_overrun, r_frame_err, w_tx_busy, r_rx_ready,
                        r_tx_done, r_rx_ie, r_tx_ie};
    assign irq       = r_irq;

    always_comb begin
        rdata = '0;
        if (mem_rd) begin
            if (w_sel_txd) begin
                rdata = {24'd0, r_txd};
            end else if (w_sel_rxd) begin
                rdata = {24'd0, r_rx_data};
            end else if (w_sel_con) begin
                rdata = {25'd0, w_con};
            end
        end
    end

    always_comb begin
        case (r_tx_state)
            ST_START: uart_tx = c_start_level;
            ST_DATA:  uart_tx = r_tx_shift[0];
            default:  uart_tx = c_stop_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
        end
    end

    always_comb begin
        w_tx_state_n  = r_tx_state;
        w_tx_cnt_n    = r_tx_cnt;
        w_tx_bit_n    = r_tx_bit;
        w_tx_shift_n  = r_tx_shift;
        w_tx_load     = 1'b0;
        w_tx_done_set = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_n = '0;
                if (w_wr_txd) begin
                    w_tx_load    = 1'b1;
                    w_tx_shift_n = wdata[7:0];
                    w_tx_bit_n   = '0;
                    w_tx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = ST_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + c_cnt_one;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_n   = r_tx_bit + 3'd1;
                    if (r_tx_bit == c_last_data_bit) begin
                        w_tx_state_n = ST_STOP;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + c_cnt_one;
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_n    = '0;
                    w_tx_done_set = 1'b1;
                    w_tx_state_n  = ST_IDLE;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + c_cnt_one;
                end
            end
            default: w_tx_state_n = ST_IDLE;
        endcase
    end

    // Status flags: a set event in the same cycle as a clearing read wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txd       <= '0;
            r_rx_data   <= '0;
            r_tx_ie     <= 1'b0;
            r_rx_ie     <= 1'b0;
            r_tx_done   <= 1'b0;
            r_rx_ready  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_tx_load) begin
                r_txd <= wdata[7:0];
            end
            if (w_wr_con) begin
                r_tx_ie <= wdata[c_con_tx_ie];
                r_rx_ie <= wdata[c_con_rx_ie];
            end
            if (w_rx_valid) begin
                r_rx_data <= w_rx_byte;
            end

            if (w_tx_done_set) begin
                r_tx_done <= 1'b1;
            end else if (w_rd_con) begin
                r_tx_done <= 1'b0;
            end

            if (w_rx_valid) begin
                r_rx_ready <= 1'b1;
            end else if (w_rd_rxd) begin
                r_rx_ready <= 1'b0;
            end

            if (w_rx_valid && r_rx_ready) begin
                r_overrun <= 1'b1;
            end else if (w_rd_rxd) begin
                r_overrun <= 1'b0;
            end

            if (w_rx_ferr) begin
                r_frame_err <= 1'b1;
            end else if (w_rd_con) begin
                r_frame_err <= 1'b0;
            end

            r_irq <= (r_tx_ie & r_tx_done) | (r_rx_ie & r_rx_ready);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_mmio_responder -- directed vectors for the MMIO UART slave
// Rev    : 1.0
// ============================================================================
module tb_uart_mmio_responder;

    localparam int          BAUD_DIV  = 16;
    localparam logic [31:0] BASE_ADDR = 32'h4000_0018;
    localparam logic [31:0] A_TXD = BASE_ADDR;
    localparam logic [31:0] A_RXD = BASE_ADDR + 32'd4;
    localparam logic [31:0] A_CON = BASE_ADDR + 32'd8;
    localparam logic [31:0] A_BAD = BASE_ADDR + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    uart_mmio_responder #(
        .BAUD_DIV (BAUD_DIV),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        mem_rd = 1'b1;
        addr   = a;
        #1 chk(nm, rdata, exp);
        @(negedge clk);
        mem_rd = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        mem_wr = 1'b1;
        addr   = a;
        wdata  = d;
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    // Called on the negedge right after the TXD write edge (first START cycle).
    task automatic tx_frame(input logic [7:0] b, input bit probe);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int c = 0; c < 10 * BAUD_DIV; c++) begin
            mem_wr = probe && (c == 40);
            mem_rd = probe && (c == 60 || c == 80);
            addr   = (c == 80) ? A_CON : A_TXD;
            wdata  = 32'h0000_00FF;
            #1 chk($sformatf("tx_bit c=%0d", c), {31'd0, uart_tx}, {31'd0, bits[c / BAUD_DIV]});
            if (probe && c == 60) chk("txd_readback_busy", rdata, {24'd0, b});
            if (probe && c == 80) chk("con_busy", rdata, 32'h11);
            @(negedge clk);
        end
        mem_wr = 1'b0;
        mem_rd = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BAUD_DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{"rst_con",      1'b0, A_CON, 32'h0,  32'h0};
        vecs[1]  = '{"rst_rxd",      1'b0, A_RXD, 32'h0,  32'h0};
        vecs[2]  = '{"rst_txd",      1'b0, A_TXD, 32'h0,  32'h0};
        vecs[3]  = '{"unmapped_rd",  1'b0, A_BAD, 32'h0,  32'h0};
        vecs[4]  = '{"wr_con_ff",    1'b1, A_CON, 32'hFF, 32'h0};
        vecs[5]  = '{"con_ie_only",  1'b0, A_CON, 32'h0,  32'h03};
        vecs[6]  = '{"wr_unmapped",  1'b1, A_BAD, 32'hFF, 32'h0};
        vecs[7]  = '{"con_unchanged",1'b0, A_CON, 32'h0,  32'h03};
        vecs[8]  = '{"wr_rxd_ro",    1'b1, A_RXD, 32'hFF, 32'h0};
        vecs[9]  = '{"rxd_ro",       1'b0, A_RXD, 32'h0,  32'h0};
        vecs[10] = '{"wr_con_01",    1'b1, A_CON, 32'h01, 32'h0};
        vecs[11] = '{"con_tx_ie",    1'b0, A_CON, 32'h0,  32'h01};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].a, vecs[i].d);
            else            bus_rd(vecs[i].a, vecs[i].exp, vecs[i].name);
        end

        // TX frame 0x5A with an ignored TXD write while busy.
        bus_wr(A_TXD, 32'h5A);
        tx_frame(8'h5A, 1'b1);
        #1 chk("irq_before_done", {31'd0, irq}, 32'd0);
        bus_rd(A_CON, 32'h05, "con_tx_done");
        #1 chk("irq_tx_rise", {31'd0, irq}, 32'd1);
        @(negedge clk);
        #1 chk("irq_tx_cleared", {31'd0, irq}, 32'd0);
        @(negedge clk);

        // RX path with rx_ie only.
        bus_wr(A_CON, 32'h02);
        rx_frame(8'hC3, 1'b1);
        #1 chk("irq_rx", {31'd0, irq}, 32'd1);
        bus_rd(A_CON, 32'h0A, "con_rx_ready");
        bus_rd(A_RXD, 32'hC3, "rxd_c3");
        @(negedge clk);
        #1 chk("irq_rx_cleared", {31'd0, irq}, 32'd0);
        bus_rd(A_CON, 32'h02, "con_after_rxd");

        rx_frame(8'h55, 1'b1);
        rx_frame(8'h3C, 1'b1);
        bus_rd(A_CON, 32'h4A, "con_overrun");
        bus_rd(A_RXD, 32'h3C, "rxd_3c");
        bus_rd(A_CON, 32'h02, "con_overrun_cleared");

        // Short low glitch must be rejected as a false start.
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_rd(A_CON, 32'h02, "con_after_glitch");
        #1 chk("irq_after_glitch", {31'd0, irq}, 32'd0);

        rx_frame(8'h81, 1'b0);
        bus_rd(A_CON, 32'h22, "con_frame_err");
        bus_rd(A_CON, 32'h02, "con_frame_err_cleared");
        bus_rd(A_RXD, 32'h3C, "rxd_kept_on_ferr");

        // Reset in the middle of a TX frame.
        bus_wr(A_TXD, 32'hA5);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("tx_idle_after_reset", {31'd0, uart_tx}, 32'd1);
        bus_rd(A_CON, 32'h00, "con_after_reset");
        bus_wr(A_TXD, 32'h96);
        tx_frame(8'h96, 1'b0);
        bus_rd(A_CON, 32'h04, "con_done_after_reset");
        bus_rd(A_TXD, 32'h96, "txd_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_mmio_responder.md
Name: uart_mmio_responder

Overview:
Memory-mapped UART slave that answers the CPU's MEM-stage data bus (rd/wr strobes, byte address, write data, read data). It provides TX/RX data registers, a control/status register and a level interrupt request to the CPU. Byte frames are 8N1, LSB first, with a fixed integer baud divisor. It sits in the peripheral region (addr[30]=1) beside the data memory, and the CPU muxes its read data.

Parameters:
BAUD_DIV, 10417, clock cycles per UART bit (100 MHz / 9600); legal range ≥ 4
BASE_ADDR, 32'h40000018, address of TXD; RXD = BASE+4, CON = BASE+8

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state on the edge where it is sampled 1
mem_rd  in  1  bus read strobe, one cycle per access
mem_wr  in  1  bus write strobe, one cycle per access
addr  in  32  byte address; full-word compare against the three register addresses
wdata  in  32  write data; only [7:0] or the CON enable bits are used
rdata  out  32  read data, combinational from addr/mem_rd; 0 when not selected
uart_rx  in  1  asynchronous serial input, idles high
uart_tx  out  1  serial output, idles high
irq  out  1  level interrupt request to the CPU

Behaviour:
- Reset: uart_tx=1, irq=0, all CON bits 0, TX/RX FSMs IDLE, rx_data=0, counters 0. Reset mid-frame aborts the frame and returns uart_tx to 1 on the next cycle.
- Register map (rdata zero-extended):
  - TXD (RW) [7:0] last byte written.
  - RXD (RO) [7:0] last received byte.
  - CON bit0 tx_ie (RW), bit1 rx_ie (RW), bit2 tx_done, bit3 rx_ready, bit4 tx_busy (RO), bit5 frame_err, bit6 overrun.
- Read: rdata is valid in the same cycle (zero-wait; the CPU samples it in MEM). Side effects take place on that cycle's clock edge:
  - Reading RXD clears rx_ready and overrun.
  - Reading CON clears tx_done and frame_err.
  - Writes to CON change only bits 1:0.
- Flag set and clear in the same cycle: set wins, so no event is lost.
- TX FSM, states IDLE → START → DATA(8) → STOP → IDLE:
  - Each bit state lasts exactly BAUD_DIV cycles.
  - A TXD write while IDLE latches wdata[7:0]. The next cycle enters START with uart_tx=0. tx_busy=1 from the cycle after the write until STOP completes.
  - A TXD write while not IDLE, including the final STOP cycle, is ignored: the TXD register and the frame are unchanged.
  - At the end of STOP: tx_done←1, FSM→IDLE.
  - Frame length is 10×BAUD_DIV cycles from the START entry.
- RX path:
  - uart_rx passes through a 2-flop synchronizer (2-cycle latency) before the FSM.
  - RX FSM, states IDLE → START → DATA(8) → STOP → IDLE.
  - IDLE: a synchronized 1→0 edge enters START.
  - START: waits BAUD_DIV/2 (integer division). If the line is sampled 1, it is a false start → IDLE with no flags changed. Otherwise it samples every BAUD_DIV cycles: 8 data bits LSB first, then the stop bit.
  - Stop bit = 1: rx_data←byte, rx_ready←1. If rx_ready was already 1, also set overrun←1; the new byte overwrites.
  - Stop bit = 0: the byte is discarded, frame_err←1, and the FSM returns to IDLE only after the line is seen high.
- irq = (tx_ie & tx_done) | (rx_ie & rx_ready), registered (1 cycle after the flag). It stays high until software clears the flag.
- Unmapped addresses: no effect, rdata=0. mem_rd and mem_wr are never both high; if they are, the write takes precedence and the read side effects are suppressed.
- Counter widths: $clog2(BAUD_DIV)+1 bits. No wrap beyond BAUD_DIV-1.

Decomposition:
- Shared package: register offsets (TXD/RXD/CON), CON bit indices, TX/RX state enum, and the 8N1 frame constants.
- One sub-module, uart_rx_core (synchronizer + RX FSM; outputs byte, valid pulse and frame_err pulse). The TX FSM and register file stay in the top module.

Test Plan:
- reset=1 for 2 cycles → uart_tx=1, irq=0, read CON=0, read RXD=0.
- BAUD_DIV=16; write TXD=0x5A → uart_tx low for 16 cycles, then bits 0,1,0,1,1,0,1,0 at 16 cycles each, stop high. tx_done sets 160 cycles after START; with tx_ie=1, irq rises 1 cycle later; reading CON drops irq.
- While tx_busy=1, write TXD=0xFF → the frame still carries 0x5A and a readback of TXD returns 0x5A.
- Drive frame 0xC3 on uart_rx with rx_ie=1 → rx_ready=1, irq=1, RXD=0xC3. Reading RXD clears rx_ready and irq. Send a second byte 0x3C without reading → overrun=1 and RXD=0x3C.
- Low glitch of 4 cycles on uart_rx → no flags change. Frame 0x81 with stop bit=0 → frame_err=1, rx_ready unchanged.
- Assert reset in the middle of a TX frame → the next cycle has uart_tx=1 and tx_busy=0; a new TXD write afterwards sends a clean frame.
